bcp_unit_scanner: RTL
=====================

Name: bcp_unit_scanner

Overview:
- Parametrised successor to the single-clause unit check in the hardware BCP datapath.
- Accepts a stream of clause evaluations over one scan (clause id, literal count, false-literal count, satisfied flag) on a valid/ready handshake.
- Classifies each clause as SAT, UNIT, CONFLICT or OPEN.
- Queues unit clause ids in an internal FIFO for the implication stage, reports the first conflict, and signals end of scan.

Parameters:
SIZE_W, 8, width of clause_size and false-literal count
CID_W, 8, width of clause id
UNIT_DEPTH, 4, unit-id FIFO depth; power of two, >=2

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin scan; honoured only in IDLE
in_valid  in  1  clause evaluation valid
in_ready  out  1  scanner accepts evaluation
in_clause_id  in  CID_W  clause index
in_clause_size  in  SIZE_W  literals in clause
in_false_cnt  in  SIZE_W  literals currently false
in_sat  in  1  clause has a true literal
in_last  in  1  final clause of scan
unit_valid  out  1  FIFO head holds a unit clause id
unit_ready  in  1  consumer pops head
unit_clause_id  out  CID_W  FIFO head
conflict  out  1  sticky: conflict seen this scan
conflict_clause_id  out  CID_W  id of first conflicting clause
unit_count  out  CID_W+1  units found this scan, saturating
busy  out  1  state is SCAN
done  out  1  one-cycle pulse at scan end

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=IDLE.
  - FIFO empty; unit_valid=0.
  - conflict=0, conflict_clause_id=0, unit_count=0, done=0, busy=0, in_ready=0.
- FSM states IDLE, SCAN, DONE:
  - IDLE -> SCAN on start. The same edge clears conflict, conflict_clause_id and unit_count, and flushes the FIFO.
  - SCAN -> DONE on the edge that accepts a beat with in_last=1.
  - DONE -> IDLE unconditionally after one cycle. done=1 only while in DONE.
  - start outside IDLE is ignored.
- Accept rule: in_ready = (state==SCAN) && (FIFO occupancy < UNIT_DEPTH). A beat is accepted when in_valid && in_ready on a rising edge.
  - The FIFO is never overwritten.
  - A pop in the same cycle does not raise in_ready. This is a registered-occupancy decision.
- Classification of an accepted beat, evaluated in priority order:
  - in_sat=1 -> SAT.
  - in_false_cnt >= in_clause_size -> CONFLICT. This includes clause_size=0 (empty clause).
  - in_false_cnt + 1 == in_clause_size -> UNIT. Compute the sum at SIZE_W+1 bits so there is no wrap at all-ones.
  - otherwise -> OPEN.
- Latency: one cycle. The effect of an accepted beat is visible the cycle after acceptance.
  - UNIT: clause id pushed to FIFO, unit_valid=1 next cycle; unit_count increments, saturating at 2^(CID_W+1)-1.
  - CONFLICT: conflict=1 next cycle. conflict_clause_id loads only if conflict was 0, so the first conflict wins. Later conflicts do not change it.
  - SAT/OPEN: no state change.
- FIFO behaviour:
  - First-word fall-through: unit_clause_id is valid whenever unit_valid=1.
  - A pop happens when unit_valid && unit_ready.
  - Pop on empty is ignored.
  - Simultaneous push and pop on a non-empty FIFO keeps occupancy unchanged.
  - Pointers wrap modulo UNIT_DEPTH.
  - FIFO contents survive DONE and IDLE until popped or until the next start flushes them.
- A last beat that is itself UNIT/CONFLICT is reflected in FIFO, conflict and unit_count on the same edge that enters DONE. These outputs are therefore final while done=1.
- An asserted reset_n low mid-scan discards everything; there is no partial result.

Optional Feature:
- Macro CONFLICT_ABORT_EN.
- Defined:
  - An accepted CONFLICT beat moves SCAN -> DONE on its accepting edge, whether or not in_last is set. in_ready drops that edge.
  - The remaining beats are left to upstream, which must discard them on done.
  - Units already queued stay in the FIFO.
- Undefined:
  - Conflicts never end the scan. Scanning continues to in_last and conflict stays sticky.

Test Plan:
- Reset mid-scan: start, accept 2 UNIT beats, assert reset_n=0 -> all outputs at reset values; unit_valid=0, state IDLE.
- Classification: beats (id,size,false,sat,last) = (1,3,2,0,0) (2,3,1,0,0) (3,3,3,0,0) (4,3,2,1,0) (5,0,0,0,1) -> FIFO holds {1}; unit_count=1; conflict=1 with id=3; done pulses one cycle after beat 5.
- Wrap boundary: size=8'hFF, false=8'hFE -> UNIT; size=8'hFF, false=8'hFF -> CONFLICT; size=8'h01, false=8'hFF -> CONFLICT. No wrap errors.
- Backpressure: UNIT_DEPTH=4, unit_ready=0, stream 6 UNIT beats ids 10..15 -> in_ready=0 after 4 accepted. Raise unit_ready -> pops 10,11,12,13 in order, then 14,15 accepted and popped; unit_count=6.
- Simultaneous push/pop with FIFO at 2 entries: accept UNIT while popping -> occupancy stays 2; order preserved.
- CONFLICT_ABORT_EN defined: beats 1 UNIT, 2 CONFLICT, 3 UNIT, with in_valid held -> enters DONE after beat 2; beat 3 not accepted; FIFO={1}; conflict_clause_id=2. Macro undefined: beat 3 accepted, FIFO={1,3}.

Source files
------------

// File: rtl/bcp_unit_scanner_if.sv
// Clause-evaluation stream and unit-id pop port of the BCP unit scanner.
// The master side is the upstream evaluator plus the implication stage;
// the slave side is the scanner itself.
interface bcp_unit_scanner_if #(
    parameter int SIZE_W = 8,
    parameter int CID_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [CID_W-1:0]  in_clause_id;
    logic [SIZE_W-1:0] in_clause_size;
    logic [SIZE_W-1:0] in_false_cnt;
    logic              in_sat;
    logic              in_last;
    logic              unit_valid;
    logic              unit_ready;
    logic [CID_W-1:0]  unit_clause_id;

    modport master (
        output in_valid, in_clause_id, in_clause_size, in_false_cnt, in_sat, in_last,
        output unit_ready,
        input  in_ready, unit_valid, unit_clause_id
    );

    modport slave (
        input  in_valid, in_clause_id, in_clause_size, in_false_cnt, in_sat, in_last,
        input  unit_ready,
        output in_ready, unit_valid, unit_clause_id
    );
endinterface

// File: rtl/bcp_unit_scanner.sv
// BCP unit scanner: classifies a stream of clause evaluations as
// SAT / UNIT / CONFLICT / OPEN, queues unit clause ids in a first-word
// fall-through FIFO, records the first conflict and pulses done at scan end.
// Optional build macro CONFLICT_ABORT_EN: an accepted conflict ends the scan.
module bcp_unit_scanner #(
    parameter int SIZE_W     = 8,
    parameter int CID_W      = 8,
    parameter int UNIT_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    bcp_unit_scanner_if.slave  bus,
    output logic               conflict,
    output logic [CID_W-1:0]   conflict_clause_id,
    output logic [CID_W:0]     unit_count,
    output logic               busy,
    output logic               done
);

    localparam int AW = (UNIT_DEPTH > 1) ? $clog2(UNIT_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(UNIT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              conflict_q;
    logic [CID_W-1:0]  conflict_id_q;
    logic [CID_W:0]    unit_count_q;

    logic [CW-1:0]     occ_q;
    logic [CW-1:0]     occ_d;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CID_W-1:0]  fifo_mem_q [UNIT_DEPTH];

    logic [SIZE_W:0]   false_plus1;
    logic              cls_conflict;
    logic              cls_unit;
    logic              start_go;
    logic              accept;
    logic              push;
    logic              pop;
    logic              end_scan;

    // Saturating increment for the unit counter; holds at all-ones.
    function automatic logic [CID_W:0] sat_inc(input logic [CID_W:0] v);
        return (&v) ? v : v + {{CID_W{1'b0}}, 1'b1};
    endfunction

    // Classification: sat dominates, then conflict (covers the empty clause),
    // then unit. The +1 is done one bit wider so all-ones sizes cannot wrap.
    assign false_plus1  = {1'b0, bus.in_false_cnt} + {{SIZE_W{1'b0}}, 1'b1};
    assign cls_conflict = !bus.in_sat && (bus.in_false_cnt >= bus.in_clause_size);
    assign cls_unit     = !bus.in_sat && !cls_conflict &&
                          (false_plus1 == {1'b0, bus.in_clause_size});

    // Ready depends only on registered state and occupancy, so a same-cycle
    // pop never opens room for a push.
    assign bus.in_ready   = (state_q == S_SCAN) && (occ_q < DEPTH_C);
    assign bus.unit_valid = (occ_q != '0);
    assign bus.unit_clause_id = fifo_mem_q[rd_ptr_q];

    assign start_go = start && (state_q == S_IDLE);
    assign accept   = bus.in_valid && bus.in_ready;
    assign push     = accept && cls_unit;
    assign pop      = bus.unit_valid && bus.unit_ready;

`ifdef CONFLICT_ABORT_EN
    assign end_scan = accept && (bus.in_last || cls_conflict);
`else
    assign end_scan = accept && bus.in_last;
`endif

    // Occupancy next-state: a push and pop together leave it unchanged.
    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Scan control FSM with registered status outputs and per-scan results.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            conflict_q    <= 1'b0;
            conflict_id_q <= '0;
            unit_count_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q       <= S_SCAN;
                        busy_q        <= 1'b1;
                        conflict_q    <= 1'b0;
                        conflict_id_q <= '0;
                        unit_count_q  <= '0;
                    end
                end
                S_SCAN: begin
                    if (accept && cls_conflict) begin
                        conflict_q <= 1'b1;
                        if (!conflict_q) begin
                            conflict_id_q <= bus.in_clause_id;
                        end
                    end
                    if (push) begin
                        unit_count_q <= sat_inc(unit_count_q);
                    end
                    if (end_scan) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a new scan flushes the queue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (start_go) begin
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            occ_q <= occ_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= bus.in_clause_id;
        end
    end

    assign conflict           = conflict_q;
    assign conflict_clause_id = conflict_id_q;
    assign unit_count         = unit_count_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule
